fmul_add_norm: RTL and testbench

FMUL_ADD_NORM -- requirements
Module: fmul_add_norm

---
 rtl/fmul_add_norm.sv | 190 +++++++++++++++++++
 tb/tb_fmul_add_norm.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_add_norm.sv
// Final two stages of a single-precision multiplier: carry-save add, then normalize/round/pack.
// Optional macro FMUL_INEXACT_EN adds a registered s_inexact output.
module fmul_add_norm (
    input  logic        clk,
    input  logic        clr,
    input  logic [39:0] a_sum,
    input  logic [39:0] a_carry,
    input  logic [7:0]  a_z8,
    input  logic [22:0] a_inf_nan_frac,
    input  logic [9:0]  a_exp10,
    input  logic [1:0]  a_rm,
    input  logic        a_sign,
    input  logic        a_is_nan,
    input  logic        a_is_inf,
    input  logic        a_valid,
    input  logic        e,
    output logic [31:0] s,
    output logic        s_valid
`ifdef FMUL_INEXACT_EN
    ,
    output logic        s_inexact
`endif
);

    localparam logic [1:0] RmNearest = 2'b00;
    localparam logic [1:0] RmZero    = 2'b01;
    localparam logic [1:0] RmPosInf  = 2'b10;
    localparam logic [1:0] RmNegInf  = 2'b11;

    // ---------------- Stage A: resolve carry-save form ----------------
    logic [39:0] upper_sum;
    logic [47:0] p48_q;
    logic [1:0]  rm_q;
    logic        sign_q;
    logic [9:0]  exp10_q;
    logic        is_nan_q;
    logic        is_inf_q;
    logic [22:0] nan_frac_q;
    logic        valid_q;

    assign upper_sum = a_sum + a_carry;

    always_ff @(posedge clk) begin
        if (clr) begin
            p48_q      <= '0;
            rm_q       <= '0;
            sign_q     <= 1'b0;
            exp10_q    <= '0;
            is_nan_q   <= 1'b0;
            is_inf_q   <= 1'b0;
            nan_frac_q <= '0;
            valid_q    <= 1'b0;
        end else if (e) begin
            p48_q      <= {upper_sum, a_z8};
            rm_q       <= a_rm;
            sign_q     <= a_sign;
            exp10_q    <= a_exp10;
            is_nan_q   <= a_is_nan;
            is_inf_q   <= a_is_inf;
            nan_frac_q <= a_inf_nan_frac;
            valid_q    <= a_valid;
        end
    end

    // ---------------- Stage N: normalize, denormalize, round ----------------
    logic signed [11:0] exp_ext;
    logic signed [11:0] exp_n;
    logic [23:0]        sig_n;
    logic               guard_n;
    logic               sticky_n;

    logic signed [11:0] sh_diff;
    logic [4:0]         sh_amt;
    logic [50:0]        wide;
    logic signed [11:0] exp_d;
    logic [23:0]        sig_d;
    logic               guard_d;
    logic               sticky_d;

    logic               inc;
    logic [24:0]        sig_r;
    logic signed [11:0] exp_r;
    logic               ovf;
    logic [31:0]        s_d;
    logic               inexact_d;

    assign exp_ext = signed'({{2{exp10_q[9]}}, exp10_q});

    always_comb begin
        if (p48_q[47]) begin
            exp_n    = exp_ext + 12'sd1;
            sig_n    = p48_q[47:24];
            guard_n  = p48_q[23];
            sticky_n = |p48_q[22:0];
        end else begin
            exp_n    = exp_ext;
            sig_n    = p48_q[46:23];
            guard_n  = p48_q[22];
            sticky_n = |p48_q[21:0];
        end
    end

    // Subnormal range: shift right by 1-exp, guard sits just below the LSB so
    // everything shifted out lands in guard or sticky.
    always_comb begin
        sh_diff  = 12'sd1 - exp_n;
        sh_amt   = '0;
        wide     = '0;
        exp_d    = exp_n;
        sig_d    = sig_n;
        guard_d  = guard_n;
        sticky_d = sticky_n;
        if (exp_n <= 12'sd0) begin
            sh_amt   = (sh_diff > 12'sd26) ? 5'd26 : sh_diff[4:0];
            wide     = {sig_n, guard_n, 26'd0} >> sh_amt;
            sig_d    = wide[50:27];
            guard_d  = wide[26];
            sticky_d = sticky_n | (|wide[25:0]);
            exp_d    = 12'sd0;
        end
    end

    always_comb begin
        unique case (rm_q)
            RmNearest: inc = guard_d & (sticky_d | sig_d[0]);
            RmZero:    inc = 1'b0;
            RmPosInf:  inc = ~sign_q & (guard_d | sticky_d);
            RmNegInf:  inc = sign_q & (guard_d | sticky_d);
            default:   inc = 1'b0;
        endcase
    end

    // A subnormal that rounds up into bit 23 becomes the smallest normal.
    always_comb begin
        sig_r = {1'b0, sig_d} + {24'd0, inc};
        if (sig_r[24]) begin
            exp_r = exp_d + 12'sd1;
        end else if ((exp_d == 12'sd0) && sig_r[23]) begin
            exp_r = 12'sd1;
        end else begin
            exp_r = exp_d;
        end
        ovf = (exp_r >= 12'sd255);
    end

    always_comb begin
        s_d       = {sign_q, exp_r[7:0], sig_r[22:0]};
        inexact_d = guard_d | sticky_d;
        if (is_nan_q) begin
            s_d       = {1'b0, 8'hFF, 1'b1, nan_frac_q[21:0]};
            inexact_d = 1'b0;
        end else if (is_inf_q) begin
            s_d       = {sign_q, 8'hFF, 23'd0};
            inexact_d = 1'b0;
        end else if (p48_q == 48'd0) begin
            s_d       = {sign_q, 31'd0};
            inexact_d = 1'b0;
        end else if (ovf) begin
            inexact_d = 1'b1;
            unique case (rm_q)
                RmNearest: s_d = {sign_q, 31'h7F800000};
                RmZero:    s_d = {sign_q, 31'h7F7FFFFF};
                RmPosInf:  s_d = sign_q ? 32'hFF7FFFFF : 32'h7F800000;
                RmNegInf:  s_d = sign_q ? 32'hFF800000 : 32'h7F7FFFFF;
                default:   s_d = {sign_q, 31'h7F800000};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            s       <= '0;
            s_valid <= 1'b0;
        end else if (e) begin
            s       <= s_d;
            s_valid <= valid_q;
        end
    end

`ifdef FMUL_INEXACT_EN
    always_ff @(posedge clk) begin
        if (clr) begin
            s_inexact <= 1'b0;
        end else if (e) begin
            s_inexact <= inexact_d;
        end
    end
`endif

endmodule

// File: tb/tb_fmul_add_norm.sv
// Directed self-checking bench for fmul_add_norm; expected values are hand-computed.
module tb_fmul_add_norm;

    logic        clk;
    logic        clr;
    logic [39:0] a_sum;
    logic [39:0] a_carry;
    logic [7:0]  a_z8;
    logic [22:0] a_inf_nan_frac;
    logic [9:0]  a_exp10;
    logic [1:0]  a_rm;
    logic        a_sign;
    logic        a_is_nan;
    logic        a_is_inf;
    logic        a_valid;
    logic        e;
    logic [31:0] s;
    logic        s_valid;
`ifdef FMUL_INEXACT_EN
    logic        s_inexact;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    fmul_add_norm dut (
        .clk            (clk),
        .clr            (clr),
        .a_sum          (a_sum),
        .a_carry        (a_carry),
        .a_z8           (a_z8),
        .a_inf_nan_frac (a_inf_nan_frac),
        .a_exp10        (a_exp10),
        .a_rm           (a_rm),
        .a_sign         (a_sign),
        .a_is_nan       (a_is_nan),
        .a_is_inf       (a_is_inf),
        .a_valid        (a_valid),
        .e              (e),
        .s              (s),
        .s_valid        (s_valid)
`ifdef FMUL_INEXACT_EN
        ,
        .s_inexact      (s_inexact)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [39:0] sum, input logic [39:0] carry, input logic [7:0] z8,
                         input logic [9:0] exp10, input logic [1:0] rm, input logic sgn,
                         input logic nan, input logic inf, input logic [22:0] frac);
        a_sum          = sum;
        a_carry        = carry;
        a_z8           = z8;
        a_exp10        = exp10;
        a_rm           = rm;
        a_sign         = sgn;
        a_is_nan       = nan;
        a_is_inf       = inf;
        a_inf_nan_frac = frac;
        a_valid        = 1'b1;
    endtask

    // One isolated transaction: capture, then result two enabled edges later.
    task automatic run_vec(input string tag, input logic [39:0] sum, input logic [39:0] carry,
                           input logic [7:0] z8, input logic [9:0] exp10, input logic [1:0] rm,
                           input logic sgn, input logic nan, input logic inf,
                           input logic [22:0] frac, input logic [31:0] exp_s);
        drive(sum, carry, z8, exp10, rm, sgn, nan, inf, frac);
        step();
        a_valid = 1'b0;
        step();
        check(tag, s, exp_s);
        check({tag, "_v"}, {31'd0, s_valid}, 32'd1);
    endtask

    initial begin
        clr = 1'b1;
        e   = 1'b1;
        drive(40'd0, 40'd0, 8'd0, 10'd0, 2'b00, 1'b0, 1'b0, 1'b0, 23'd0);
        a_valid = 1'b0;
        step();
        step();
        check("reset_s", s, 32'd0);
        check("reset_v", {31'd0, s_valid}, 32'd0);
        clr = 1'b0;

        // Normal and rounding
        run_vec("norm_2p25", 40'h8000000000, 40'h1000000000, 8'h00, 10'd127, 2'b00, 1'b0,
                1'b0, 1'b0, 23'd0, 32'h40100000);
`ifdef FMUL_INEXACT_EN
        check("norm_inexact", {31'd0, s_inexact}, 32'd0);
`endif
        run_vec("rne_tie_odd", 40'h400000C000, 40'd0, 8'h00, 10'd127, 2'b00, 1'b0,
                1'b0, 1'b0, 23'd0, 32'h3F800002);
        run_vec("rtz_trunc", 40'h400000C000, 40'd0, 8'h00, 10'd127, 2'b01, 1'b0,
                1'b0, 1'b0, 23'd0, 32'h3F800001);
        run_vec("rup_z8_sticky", 40'h4000000000, 40'd0, 8'h01, 10'd127, 2'b10, 1'b0,
                1'b0, 1'b0, 23'd0, 32'h3F800001);
        run_vec("rne_z8_sticky", 40'h4000000000, 40'd0, 8'h01, 10'd127, 2'b00, 1'b0,
                1'b0, 1'b0, 23'd0, 32'h3F800000);
        run_vec("round_carry_ovf", 40'h7FFFFFFFFF, 40'd0, 8'hFF, 10'd254, 2'b00, 1'b0,
                1'b0, 1'b0, 23'd0, 32'h7F800000);

        // Overflow, negative sign, each rounding mode
        run_vec("ovf_rne", 40'h4000000000, 40'd0, 8'h00, 10'd300, 2'b00, 1'b1,
                1'b0, 1'b0, 23'd0, 32'hFF800000);
        run_vec("ovf_rtz", 40'h4000000000, 40'd0, 8'h00, 10'd300, 2'b01, 1'b1,
                1'b0, 1'b0, 23'd0, 32'hFF7FFFFF);
        run_vec("ovf_rup", 40'h4000000000, 40'd0, 8'h00, 10'd300, 2'b10, 1'b1,
                1'b0, 1'b0, 23'd0, 32'hFF7FFFFF);
        run_vec("ovf_rdn", 40'h4000000000, 40'd0, 8'h00, 10'd300, 2'b11, 1'b1,
                1'b0, 1'b0, 23'd0, 32'hFF800000);

        // Specials and zero
        run_vec("nan", 40'h4000000000, 40'd0, 8'h00, 10'd127, 2'b00, 1'b1,
                1'b1, 1'b0, 23'h400000, 32'h7FC00000);
        run_vec("inf_neg", 40'h4000000000, 40'd0, 8'h00, 10'd127, 2'b00, 1'b1,
                1'b0, 1'b1, 23'd0, 32'hFF800000);
        run_vec("nan_over_inf", 40'h4000000000, 40'd0, 8'h00, 10'd127, 2'b00, 1'b1,
                1'b1, 1'b1, 23'h400000, 32'h7FC00000);
        run_vec("zero_neg", 40'd0, 40'd0, 8'h00, 10'd127, 2'b00, 1'b1,
                1'b0, 1'b0, 23'd0, 32'h80000000);

        // Subnormal results
        run_vec("subn_shift2", 40'h4000000000, 40'd0, 8'h00, 10'h3FF, 2'b00, 1'b0,
                1'b0, 1'b0, 23'd0, 32'h00200000);
        run_vec("subn_tie_even", 40'h6000000000, 40'd0, 8'h00, 10'h3EA, 2'b00, 1'b0,
                1'b0, 1'b0, 23'd0, 32'h00000002);
`ifdef FMUL_INEXACT_EN
        check("subn_inexact", {31'd0, s_inexact}, 32'd1);
`endif

        // Stall: start from cleared pipeline so the held value is known (zero)
        clr = 1'b1;
        step();
        clr = 1'b0;
        drive(40'h8000000000, 40'h1000000000, 8'h00, 10'd127, 2'b00, 1'b0, 1'b0, 1'b0, 23'd0);
        step();
        a_valid = 1'b0;
        e = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_s", s, 32'd0);
            check("stall_v", {31'd0, s_valid}, 32'd0);
        end
        e = 1'b1;
        step();
        check("stall_out_s", s, 32'h40100000);
        check("stall_out_v", {31'd0, s_valid}, 32'd1);
        e = 1'b0;
        step();
        check("hold_s", s, 32'h40100000);
        check("hold_v", {31'd0, s_valid}, 32'd1);
        e = 1'b1;

        // Back-to-back, one result per cycle in order
        drive(40'h8000000000, 40'h1000000000, 8'h00, 10'd127, 2'b00, 1'b0, 1'b0, 1'b0, 23'd0);
        step();
        drive(40'h4000000000, 40'd0, 8'h00, 10'd300, 2'b01, 1'b1, 1'b0, 1'b0, 23'd0);
        step();
        check("b2b_0", s, 32'h40100000);
        check("b2b_0_v", {31'd0, s_valid}, 32'd1);
        drive(40'h4000000000, 40'd0, 8'h00, 10'h3FF, 2'b00, 1'b0, 1'b0, 1'b0, 23'd0);
        step();
        check("b2b_1", s, 32'hFF7FFFFF);
        check("b2b_1_v", {31'd0, s_valid}, 32'd1);
        a_valid = 1'b0;
        step();
        check("b2b_2", s, 32'h00200000);
        check("b2b_2_v", {31'd0, s_valid}, 32'd1);
        step();
        check("b2b_end_v", {31'd0, s_valid}, 32'd0);

        // Reset with both stages occupied
        drive(40'h8000000000, 40'h1000000000, 8'h00, 10'd127, 2'b00, 1'b0, 1'b0, 1'b0, 23'd0);
        step();
        drive(40'h4000000000, 40'd0, 8'h00, 10'd127, 2'b00, 1'b1, 1'b0, 1'b0, 23'd0);
        step();
        a_valid = 1'b0;
        clr = 1'b1;
        step();
        check("clr_s", s, 32'd0);
        check("clr_v", {31'd0, s_valid}, 32'd0);
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_clr_v", {31'd0, s_valid}, 32'd0);
        end

        // Reset overrides a stalled pipeline
        run_vec("pre_clr_e0", 40'h8000000000, 40'h1000000000, 8'h00, 10'd127, 2'b00, 1'b0,
                1'b0, 1'b0, 23'd0, 32'h40100000);
        e = 1'b0;
        clr = 1'b1;
        step();
        check("clr_e0_s", s, 32'd0);
        check("clr_e0_v", {31'd0, s_valid}, 32'd0);
        clr = 1'b0;
        e = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
